// File: rtl/key_debounce_pkg.sv
// Shared definitions for the front-panel key conditioning blocks:
// FSM state encodings, default timing constants and a small sizing helper.
package key_debounce_pkg;

  // 20 ms, 1 s and 200 ms at 50 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_LONG_CYCLES     = 50000000;
  localparam int unsigned DEFAULT_REPEAT_CYCLES   = 10000000;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRESS_FILT = 3'd1;
  localparam logic [2:0] ST_PRESSED    = 3'd2;
  localparam logic [2:0] ST_HELD       = 3'd3;
  localparam logic [2:0] ST_REL_FILT   = 3'd4;

  typedef enum logic [2:0] {
    StIdle      = ST_IDLE,
    StPressFilt = ST_PRESS_FILT,
    StPressed   = ST_PRESSED,
    StHeld      = ST_HELD,
    StRelFilt   = ST_REL_FILT
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button-side signal bundle: raw key in, debounced level and event pulses out.
interface key_debounce_if;

  logic key_in;
  logic key_out;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;

  // Driver of the raw key and consumer of the conditioned outputs.
  modport master (
    output key_in,
    input  key_out, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  // The debouncer itself.
  modport slave (
    input  key_in,
    output key_out, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

endinterface

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module key_debounce_sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low button and generates press, release, long-press and
// auto-repeat pulses from the filtered level.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input logic            clk,
  input logic            rst_n,
  key_debounce_if.slave  bus
);

  localparam int unsigned MaxCycles = max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CntW      = $clog2(MaxCycles);

  localparam logic [CntW-1:0] DbLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] LngLast = CntW'(LONG_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);

  logic key_sync;

  key_debounce_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.key_in),
    .q     (key_sync)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            held_q, held_d;
  logic            key_out_q, key_out_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      key_out_q <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      key_out_q <= key_out_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // In every state the input level is tested before the terminal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    key_out_d = key_out_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        key_out_d = 1'b1;
        if (!key_sync) begin
          state_d = StPressFilt;
          cnt_d   = '0;
        end
      end
      StPressFilt: begin
        if (key_sync) begin
          state_d = StIdle;
        end else if (cnt_q == DbLast) begin
          state_d   = StPressed;
          key_out_d = 1'b0;
          press_d   = 1'b1;
          cnt_d     = '0;
          held_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (key_sync) begin
          state_d = StRelFilt;
          cnt_d   = '0;
        end else if (cnt_q == LngLast) begin
          state_d = StHeld;
          long_d  = 1'b1;
          cnt_d   = '0;
          held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHeld: begin
        if (key_sync) begin
          state_d = StRelFilt;
          cnt_d   = '0;
        end else if (cnt_q == RepLast) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelFilt: begin
        if (!key_sync) begin
          // Bounce during release: resume holding, timers restart from zero.
          state_d = held_q ? StHeld : StPressed;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d   = StIdle;
          key_out_d = 1'b1;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.key_out       = key_out_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing constants; edge numbers are
// counted from the first posedge after key_in changes.
module tb_key_debounce;

  localparam int unsigned DB = 4;
  localparam int unsigned LG = 20;
  localparam int unsigned RP = 8;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_PRS  = 4'b1000;
  localparam logic [3:0] P_REL  = 4'b0100;
  localparam logic [3:0] P_LNG  = 4'b0010;
  localparam logic [3:0] P_REP  = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  key_debounce_if bus ();

  key_debounce #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LG),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] pv;
  assign pv = {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic exp_k, input logic [3:0] exp_p);
    check({tag, " key_out"}, 32'(bus.key_out), 32'(exp_k));
    check({tag, " pulses"}, 32'(pv), 32'(exp_p));
  endtask

  logic       exp_k;
  logic [3:0] exp_p;

  initial begin
    bus.key_in = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("in_reset", 1'b1, P_NONE);
    rst_n = 1'b1;

    // Idle after reset with the key released.
    for (int e = 0; e < 100; e++) begin
      step();
      check_state($sformatf("idle e%0d", e), 1'b1, P_NONE);
    end

    // Press and hold: press at 6, long at 26, repeats every 8 edges.
    bus.key_in = 1'b0;
    for (int e = 0; e <= 55; e++) begin
      step();
      exp_k = (e >= 6) ? 1'b0 : 1'b1;
      exp_p = P_NONE;
      if (e == 6) exp_p = P_PRS;
      if (e == 26) exp_p = P_LNG;
      if (e == 34 || e == 42 || e == 50) exp_p = P_REP;
      check_state($sformatf("hold e%0d", e), exp_k, exp_p);
    end

    // Release from HELD; the release is seen on the same edge the repeat timer expires.
    bus.key_in = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      step();
      exp_k = (e >= 6) ? 1'b1 : 1'b0;
      exp_p = (e == 6) ? P_REL : P_NONE;
      check_state($sformatf("rel_held e%0d", e), exp_k, exp_p);
    end

    // Short low bounces are rejected.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) begin
        bus.key_in = (i < 3) ? 1'b0 : 1'b1;
        step();
        check_state($sformatf("bounce r%0d i%0d", r, i), 1'b1, P_NONE);
      end
    end
    for (int e = 0; e < 4; e++) begin
      step();
      check_state($sformatf("bounce_tail e%0d", e), 1'b1, P_NONE);
    end

    // Press, release after 10 held edges with a 2-edge low glitch in the release filter.
    for (int e = 0; e <= 35; e++) begin
      if (e <= 16)      bus.key_in = 1'b0;
      else if (e <= 18) bus.key_in = 1'b1;
      else if (e <= 20) bus.key_in = 1'b0;
      else              bus.key_in = 1'b1;
      step();
      exp_k = (e >= 6 && e < 27) ? 1'b0 : 1'b1;
      exp_p = P_NONE;
      if (e == 6) exp_p = P_PRS;
      if (e == 27) exp_p = P_REL;
      check_state($sformatf("glitch e%0d", e), exp_k, exp_p);
    end

    // Reach HELD, then reset asynchronously while long_pulse is high.
    bus.key_in = 1'b0;
    for (int e = 0; e <= 26; e++) begin
      step();
      exp_k = (e >= 6) ? 1'b0 : 1'b1;
      exp_p = P_NONE;
      if (e == 6) exp_p = P_PRS;
      if (e == 26) exp_p = P_LNG;
      check_state($sformatf("pre_rst e%0d", e), exp_k, exp_p);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 1'b1, P_NONE);
    step();
    step();
    check_state("rst_hold", 1'b1, P_NONE);
    rst_n = 1'b1;

    // Key still held: re-qualified as a fresh press.
    for (int e = 0; e <= 7; e++) begin
      step();
      exp_k = (e >= 6) ? 1'b0 : 1'b1;
      exp_p = (e == 6) ? P_PRS : P_NONE;
      check_state($sformatf("post_rst e%0d", e), exp_k, exp_p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
Upstream conditioning stage for front-panel buttons in the waveform generator. It synchronises a raw, bouncing, active-low button input and filters it into a clean level (key_out), which feeds the key edge-detector stage. It also emits single-cycle press, release, long-press and auto-repeat pulses, which the wave-control logic uses for fast parameter stepping.

Parameters:
DEBOUNCE_CYCLES, 1000000, clocks the synchronised input must stay at a new level before it is accepted (20 ms at 50 MHz); minimum 2.
LONG_CYCLES, 50000000, clocks of accepted press before long_pulse fires (1 s); minimum 2.
REPEAT_CYCLES, 10000000, clocks between repeat_pulse outputs while held after long press (200 ms); minimum 2.

Ports:
clk  input  1  system clock; all logic on posedge clk.
rst_n  input  1  asynchronous active-low reset.
key_in  input  1  raw button (0 = pressed, 1 = released); asynchronous to clk.
key_out  output  1  debounced level, same polarity as key_in.
press_pulse  output  1  one-cycle pulse when a press is accepted.
release_pulse  output  1  one-cycle pulse when a release is accepted.
long_pulse  output  1  one-cycle pulse when the press has been held LONG_CYCLES.
repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES after long_pulse, while held.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: key_out=1; all pulses=0; state=IDLE; cnt=0; held flag=0; both synchroniser flops=1 (released).
- key_in passes through a 2-flop synchroniser (s1, s2). The FSM acts only on s2.
- Counter cnt is wide enough for max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)-1 ($clog2). It never wraps because it is cleared on every terminal count.
- All pulses are registered and default to 0 every cycle. Each is high for exactly one cycle.
- FSM states:
  IDLE: key_out=1. If s2=0, go to PRESS_FILT with cnt=0.
  PRESS_FILT: if s2=1, return to IDLE (bounce rejected, no pulse). Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED with key_out<=0, press_pulse<=1, cnt=0, held=0. Otherwise cnt++.
  PRESSED: if s2=1, go to REL_FILT with cnt=0. Else if cnt==LONG_CYCLES-1, go to HELD with long_pulse<=1, cnt=0, held=1. Otherwise cnt++.
  HELD: if s2=1, go to REL_FILT with cnt=0. Else if cnt==REPEAT_CYCLES-1, repeat_pulse<=1 and cnt=0. Otherwise cnt++.
  REL_FILT: if s2=0 (bounce), return to HELD if held=1, else PRESSED, with cnt=0. The long/repeat timer restarts; no pulse is issued. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE with key_out<=1, release_pulse<=1, held=0. Otherwise cnt++.
- Latency: key_in changes before edge 0 and is stable thereafter. key_out and press/release_pulse update at edge DEBOUNCE_CYCLES+2 (2 synchroniser edges + 1 detect edge + DEBOUNCE_CYCLES-1 count edges).
- long_pulse fires LONG_CYCLES edges after press acceptance. Each repeat_pulse follows the previous long/repeat pulse by REPEAT_CYCLES edges.
- A release accepted during PRESSED produces release_pulse only; long_pulse never fires.
- Glitches shorter than DEBOUNCE_CYCLES never change key_out.
- Simultaneous events: the s2 level check has priority over the terminal count in every state.
- Reset mid-operation forces the reset values immediately. A button held through reset is re-qualified as a fresh press after reset.
- key_out is held in a register, never decoded from state, so it is glitch-free.

Decomposition:
- Shared package/include holds the state encodings (IDLE, PRESS_FILT, PRESSED, HELD, REL_FILT as 3-bit localparams) and the default timing constants, so sibling key blocks reuse them.
- One natural sub-module: sync_2ff, a 2-flop synchroniser with a reset-value parameter. It is instantiated here and is reusable for other asynchronous inputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8):
1. Reset release with key_in=1 held -> key_out=1, all pulses 0 for 100 cycles.
2. key_in 1->0 before edge 0, held low -> key_out=0 and press_pulse=1 after edge 6; press_pulse=0 after edge 7.
3. Continue holding -> long_pulse after edge 26; repeat_pulse after edges 34, 42, 50; no other pulses.
4. Bounce: key_in low for 3 cycles then high, repeated 5 times -> key_out stays 1, zero pulses.
5. Press accepted, then release after 10 cycles with a 2-cycle low glitch inside the release window -> release_pulse only after a stable 4-cycle high filter; long_pulse never fires.
6. Assert rst_n=0 asynchronously mid-HELD -> key_out=1 and pulses 0 immediately. With key_in still low after reset release -> press_pulse 6 edges later.
